// File: rtl/replay_issue_buffer_pkg.sv
// Shared types and default constants for the replay issue buffer.
package replay_issue_buffer_pkg;

    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefDepth     = 4;
    localparam int unsigned DefMaxReplay = 3;
    localparam int unsigned DefBackoff   = 2;

    // Issue FSM: either presenting the head or waiting out a post-replay backoff.
    typedef enum logic [0:0] {
        StReady,
        StBackoff
    } state_e;

endpackage

// File: rtl/replay_issue_fifo.sv
// Circular payload storage with wrapping read/write pointers and occupancy count.
module replay_issue_fifo
    import replay_issue_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CntW-1:0]   count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and count; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head payload and occupancy.
    always_comb begin
        head_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule

// File: rtl/replay_issue_buffer.sv
// FIFO issue buffer that reissues rejected heads after a backoff and drops
// entries that exceed the replay limit.
module replay_issue_buffer
    import replay_issue_buffer_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned MAX_REPLAY = DefMaxReplay,
    parameter int unsigned BACKOFF    = DefBackoff,
    localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_enq_valid,
    output logic              io_enq_ready,
    input  logic [DATA_W-1:0] io_enq_bits,
    output logic              io_valid,
    output logic [DATA_W-1:0] io_bits,
    input  logic              io_replay,
    input  logic              io_flush,
    output logic              io_drop_valid,
    output logic [DATA_W-1:0] io_drop_bits,
    output logic [CntW-1:0]   io_count
);

    localparam int unsigned RcW = (MAX_REPLAY > 0) ? $clog2(MAX_REPLAY + 1) : 1;
    localparam int unsigned BoW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

    state_e            state_q, state_d;
    logic [RcW-1:0]    replay_cnt_q, replay_cnt_d;
    logic [BoW-1:0]    bo_cnt_q, bo_cnt_d;
    logic              drop_valid_q, drop_valid_d;
    logic [DATA_W-1:0] drop_bits_q, drop_bits_d;

    logic [CntW-1:0]   fifo_count;
    logic [DATA_W-1:0] head;
    logic              push, pop, retire, drop;

    replay_issue_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (io_flush),
        .push_i      (push),
        .push_data_i (io_enq_bits),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // Handshakes and outputs; a same-cycle retire never frees space for enqueue.
    always_comb begin
        io_enq_ready  = (fifo_count < CntW'(DEPTH)) && !io_flush && !reset;
        io_valid      = (state_q == StReady) && (fifo_count != '0) && !io_flush && !reset;
        io_bits       = head;
        retire        = io_valid && !io_replay;
        drop          = io_valid && io_replay && (replay_cnt_q == RcW'(MAX_REPLAY));
        push          = io_enq_valid && io_enq_ready;
        pop           = retire || drop;
        io_drop_valid = drop_valid_q && !reset;
        io_drop_bits  = drop_bits_q;
        io_count      = fifo_count;
    end

    // Issue FSM next-state: replay handling, backoff countdown and drop pulse.
    always_comb begin
        state_d      = state_q;
        replay_cnt_d = replay_cnt_q;
        bo_cnt_d     = bo_cnt_q;
        drop_valid_d = 1'b0;
        drop_bits_d  = drop_bits_q;
        if (io_flush) begin
            state_d      = StReady;
            replay_cnt_d = '0;
            bo_cnt_d     = '0;
        end else begin
            unique case (state_q)
                StReady: begin
                    if (io_valid) begin
                        if (!io_replay) begin
                            replay_cnt_d = '0;
                        end else if (drop) begin
                            replay_cnt_d = '0;
                            drop_valid_d = 1'b1;
                            drop_bits_d  = head;
                        end else begin
                            replay_cnt_d = replay_cnt_q + 1'b1;
                            // Countdown reaches zero on the last idle cycle.
                            bo_cnt_d     = BoW'(BACKOFF - 1);
                            state_d      = StBackoff;
                        end
                    end
                end
                StBackoff: begin
                    if (bo_cnt_q == '0) begin
                        state_d = StReady;
                    end else begin
                        bo_cnt_d = bo_cnt_q - 1'b1;
                    end
                end
                default: state_d = StReady;
            endcase
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StReady;
            replay_cnt_q <= '0;
            bo_cnt_q     <= '0;
            drop_valid_q <= 1'b0;
            drop_bits_q  <= '0;
        end else begin
            state_q      <= state_d;
            replay_cnt_q <= replay_cnt_d;
            bo_cnt_q     <= bo_cnt_d;
            drop_valid_q <= drop_valid_d;
            drop_bits_q  <= drop_bits_d;
        end
    end

endmodule

// File: doc/replay_issue_buffer.md
REPLAY_ISSUE_BUFFER -- requirements
Module: replay_issue_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning request payload width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning buffer entries (power of 2).
REQ-003 SHALL have parameter MAX_REPLAY, default 3, meaning replays allowed before an entry is dropped.
REQ-004 SHALL have parameter BACKOFF, default 2, meaning idle cycles after a replay before reissue (>=1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port io_enq_valid, input, 1 bit: an upstream request is offered.
REQ-008 SHALL have port io_enq_ready, output, 1 bit: the buffer accepts the request this cycle.
REQ-009 SHALL have port io_enq_bits, input, DATA_W bits: request payload.
REQ-010 SHALL have port io_valid, output, 1 bit: the head entry is issued to the downstream replay-check blocks.
REQ-011 SHALL have port io_bits, output, DATA_W bits: head payload; defined only while io_valid=1.
REQ-012 SHALL have port io_replay, input, 1 bit: same-cycle combinational reject from downstream, qualified by io_valid.
REQ-013 SHALL have port io_flush, input, 1 bit: discard all buffered entries.
REQ-014 SHALL have port io_drop_valid, output, 1 bit: one-cycle pulse reporting an entry dropped after MAX_REPLAY replays.
REQ-015 SHALL have port io_drop_bits, output, DATA_W bits: payload of the dropped entry.
REQ-016 SHALL have port io_count, output, clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-017 SHALL store entries in FIFO order; enqueue occurs when io_enq_valid & io_enq_ready.
REQ-018 SHALL drive io_enq_ready = (count < DEPTH) & !io_flush & !reset; a same-cycle retire does not free space for that cycle's enqueue.
REQ-019 SHALL implement FSM states READY and BACKOFF.
REQ-020 SHALL drive io_valid = (state==READY) & (count!=0) & !io_flush; an entry enqueued in cycle t is issuable in cycle t+1 at the earliest.
REQ-021 SHALL, on io_valid & !io_replay, retire the head, clear the head replay counter and remain READY, allowing back-to-back issue.
REQ-022 SHALL, on io_valid & io_replay with replay counter < MAX_REPLAY, keep the head, increment the counter and enter BACKOFF.
REQ-023 SHALL hold io_valid=0 for exactly BACKOFF cycles in BACKOFF, then return to READY and reissue the same head.
REQ-024 SHALL, on io_valid & io_replay with replay counter == MAX_REPLAY, remove the head, clear the counter, remain READY, and register io_drop_valid=1 and io_drop_bits=payload for the following cycle only.
REQ-025 SHALL ignore io_replay whenever io_valid=0.
REQ-026 SHALL give io_flush top priority: count, pointers and replay counter go to 0, state goes to READY, no enqueue, no retire and no drop pulse for flushed entries.
REQ-027 SHALL update io_count as count + enq - (retire|drop), saturating neither way; simultaneous enqueue and retire leave it unchanged.
REQ-028 SHALL wrap read/write pointers modulo DEPTH without bubbles.

Reset
REQ-029 SHALL, while reset=1, force io_enq_ready=0, io_valid=0, io_drop_valid=0.
REQ-030 SHALL on reset clear count, pointers, replay counter and backoff counter, set state READY, and make io_enq_ready=1 the first cycle after reset deasserts.
REQ-031 SHALL, on reset mid-BACKOFF or mid-stream, discard all entries with no drop pulse.

Structure
REQ-032 SHALL place the FSM state encoding and default parameter constants in the shared package.
REQ-033 SHALL implement the circular storage (data array, pointers, count) as sub-module replay_issue_fifo; FSM and counters live in the top.

Verification (DEPTH=4, MAX_REPLAY=3, BACKOFF=2)
REQ-034 SHALL cover: enqueue 0xA,0xB,0xC in cycles 0-2, io_replay=0 -> io_valid in cycles 1-3 with bits 0xA,0xB,0xC; io_count ends 0.
REQ-035 SHALL cover: enqueue 0x11, io_replay=1 on first issue (cycle 1) -> io_valid=0 cycles 2-3, reissue 0x11 cycle 4; io_replay=0 retires it.
REQ-036 SHALL cover: 0x22 with io_replay held 1 -> issued 4 times (cycles 1,4,7,10), io_drop_valid=1 with bits 0x22 in cycle 11 only, io_count=0.
REQ-037 SHALL cover: 4 enqueues with io_replay=1 -> io_count=4, io_enq_ready=0, a 5th offer is held; after a retire, io_enq_ready=1 the next cycle.
REQ-038 SHALL cover: io_flush during BACKOFF with 3 entries -> next cycle io_count=0, io_valid=0, no drop pulse; new enqueue issues normally.
REQ-039 SHALL cover: reset asserted mid-BACKOFF for 1 cycle -> outputs as REQ-029, then io_count=0, io_enq_ready=1.
